// File: rtl/decoder_bank.sv
// decoder_bank: enable-gated 3-to-8 and 1-to-2 one-hot decoders with registered copies.
//
// Ports:
//   clk        in   1  system clock, rising edge
//   rst        in   1  synchronous active-high reset (registered outputs only)
//   ena        in   1  shared enable; 0 forces every decoded line low
//   in         in   3  select for the 3-to-8 decoder
//   in_1_2     in   1  select for the 1-to-2 decoder
//   out        out  8  combinational one-hot decode of in
//   out_1_2    out  2  combinational one-hot decode of in_1_2
//   out_q      out  8  registered copy of out
//   out_1_2_q  out  2  registered copy of out_1_2
//   onehot_err out  1  sticky self-check flag, present only when DECODER_ONEHOT_CHECK_EN is defined
//
// Optional feature macro: DECODER_ONEHOT_CHECK_EN

// Leaf stage: a disabled stage drives both lines low; AND-gating keeps X selects
// from leaking through when disabled.
module decoder_bank_dec_1_2 (
    input  logic       en,
    input  logic       sel,
    output logic [1:0] y
);
    assign y = {en & sel, en & ~sel};
endmodule

// 2-to-4 stage: one 1-to-2 on sel[1] enabling two 1-to-2 stages on sel[0].
module decoder_bank_dec_2_4 (
    input  logic       en,
    input  logic [1:0] sel,
    output logic [3:0] y
);
    logic [1:0] e;
    decoder_bank_dec_1_2 u_hi  (.en(en),   .sel(sel[1]), .y(e));
    decoder_bank_dec_1_2 u_lo0 (.en(e[0]), .sel(sel[0]), .y(y[1:0]));
    decoder_bank_dec_1_2 u_lo1 (.en(e[1]), .sel(sel[0]), .y(y[3:2]));
endmodule

module decoder_bank (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [2:0] in,
    input  logic       in_1_2,
    output logic [7:0] out,
    output logic [1:0] out_1_2,
    output logic [7:0] out_q,
    output logic [1:0] out_1_2_q
`ifdef DECODER_ONEHOT_CHECK_EN
    ,
    output logic       onehot_err
`endif
);
    logic [1:0] e;

    // in[2] picks which 2-to-4 half is enabled.
    decoder_bank_dec_1_2 u_top (.en(ena),  .sel(in[2]),   .y(e));
    decoder_bank_dec_2_4 u_lo  (.en(e[0]), .sel(in[1:0]), .y(out[3:0]));
    decoder_bank_dec_2_4 u_hi  (.en(e[1]), .sel(in[1:0]), .y(out[7:4]));
    decoder_bank_dec_1_2 u_s   (.en(ena),  .sel(in_1_2),  .y(out_1_2));

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q     <= 8'h00;
            out_1_2_q <= 2'b00;
        end else begin
            out_q     <= out;
            out_1_2_q <= out_1_2;
        end
    end

`ifdef DECODER_ONEHOT_CHECK_EN
    logic oh8, oh2, bad;
    always_comb begin
        oh8 = (out != 8'd0) && ((out & (out - 8'd1)) == 8'd0);
        oh2 = (out_1_2 == 2'b01) || (out_1_2 == 2'b10);
        bad = ena ? !(oh8 && oh2) : |{out, out_1_2};
    end

    always_ff @(posedge clk) begin
        if (rst) onehot_err <= 1'b0;
        else if (bad) onehot_err <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_decoder_bank.sv
// tb_decoder_bank: randomized and directed self-check of decoder_bank against a behavioural model.
module tb_decoder_bank;
    logic       clk = 1'b0;
    logic       rst, ena, in_1_2;
    logic [2:0] in;
    logic [7:0] out, out_q;
    logic [1:0] out_1_2, out_1_2_q;
`ifdef DECODER_ONEHOT_CHECK_EN
    logic       onehot_err;
`endif
    int total = 0;
    int passed = 0;

    decoder_bank dut (
        .clk(clk), .rst(rst), .ena(ena), .in(in), .in_1_2(in_1_2),
        .out(out), .out_1_2(out_1_2), .out_q(out_q), .out_1_2_q(out_1_2_q)
`ifdef DECODER_ONEHOT_CHECK_EN
        , .onehot_err(onehot_err)
`endif
    );

    always #5 clk = ~clk;

    // Model: a hot bit at position = select, weight 2**select, only when enabled.
    function automatic logic [7:0] ref8(input logic e, input int s);
        return e ? 8'(2 ** s) : 8'h00;
    endfunction

    function automatic logic [1:0] ref2(input logic e, input int s);
        return e ? 2'(2 ** s) : 2'b00;
    endfunction

    task automatic drive(input logic r, input logic e, input logic [2:0] s, input logic s12);
        @(negedge clk);
        rst = r; ena = e; in = s; in_1_2 = s12;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 3'd5, 1'b1);
        tick();
        total++;
        if (out_q !== 8'h00) $display("FAIL reset_out_q got=%b exp=%b", out_q, 8'h00);
        else passed++;
        total++;
        if (out_1_2_q !== 2'b00) $display("FAIL reset_out_1_2_q got=%b exp=%b", out_1_2_q, 2'b00);
        else passed++;
`ifdef DECODER_ONEHOT_CHECK_EN
        total++;
        if (onehot_err !== 1'b0) $display("FAIL reset_onehot_err got=%b exp=0", onehot_err);
        else passed++;
`endif
    endtask

    task automatic test_sweep(input logic e);
        for (int s = 0; s < 8; s++) begin
            drive(1'b0, e, 3'(s), 1'b0);
            total++;
            if (out !== ref8(e, s)) $display("FAIL sweep_out ena=%0d in=%0d got=%b exp=%b", e, s, out, ref8(e, s));
            else passed++;
            tick();
            total++;
            if (out_q !== ref8(e, s)) $display("FAIL sweep_out_q ena=%0d in=%0d got=%b exp=%b", e, s, out_q, ref8(e, s));
            else passed++;
        end
    endtask

    task automatic test_1_2();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, logic'(k < 2), 3'd0, logic'(k % 2));
            total++;
            if (out_1_2 !== ref2(k < 2, k % 2)) $display("FAIL dec12 ena=%0d sel=%0d got=%b exp=%b", k < 2, k % 2, out_1_2, ref2(k < 2, k % 2));
            else passed++;
            tick();
            total++;
            if (out_1_2_q !== ref2(k < 2, k % 2)) $display("FAIL dec12_q ena=%0d sel=%0d got=%b exp=%b", k < 2, k % 2, out_1_2_q, ref2(k < 2, k % 2));
            else passed++;
        end
    endtask

    task automatic test_disabled_x();
        drive(1'b0, 1'b0, 3'bxxx, 1'bx);
        total++;
        if ({out, out_1_2} !== 10'd0) $display("FAIL disabled_x got=%b exp=0", {out, out_1_2});
        else passed++;
        tick();
    endtask

    task automatic test_rst_mid();
        drive(1'b0, 1'b1, 3'd5, 1'b0);
        tick();
        total++;
        if (out_q !== 8'b0010_0000) $display("FAIL rst_mid_pre got=%b exp=00100000", out_q);
        else passed++;
        drive(1'b1, 1'b1, 3'd5, 1'b0);
        tick();
        total++;
        if (out_q !== 8'h00 || out_1_2_q !== 2'b00) $display("FAIL rst_mid_clear got=%b/%b exp=0/0", out_q, out_1_2_q);
        else passed++;
        total++;
        if (out !== 8'b0010_0000) $display("FAIL rst_mid_comb got=%b exp=00100000", out);
        else passed++;
        drive(1'b0, 1'b1, 3'd5, 1'b0);
        tick();
        total++;
        if (out_q !== 8'b0010_0000) $display("FAIL rst_mid_after got=%b exp=00100000", out_q);
        else passed++;
    endtask

    task automatic test_independence();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b1, 3'd3, logic'(k % 2));
            total++;
            if (out !== 8'b0000_1000) $display("FAIL indep_out sel12=%0d got=%b exp=00001000", k % 2, out);
            else passed++;
        end
        for (int s = 0; s < 8; s++) begin
            drive(1'b0, 1'b1, 3'(s), 1'b1);
            total++;
            if (out_1_2 !== 2'b10) $display("FAIL indep_out_1_2 in=%0d got=%b exp=10", s, out_1_2);
            else passed++;
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_q;
        logic [1:0] exp_q2;
        logic       r, e, s12;
        logic [2:0] s;
        for (int n = 0; n < 200; n++) begin
            r = ($urandom_range(0, 15) == 0);
            e = ($urandom_range(0, 3) != 0);
            s = 3'($urandom_range(0, 7));
            s12 = 1'($urandom_range(0, 1));
            drive(r, e, s, s12);
            total++;
            if (out !== ref8(e, int'(s)) || out_1_2 !== ref2(e, int'(s12)))
                $display("FAIL rand_comb n=%0d got=%b/%b exp=%b/%b", n, out, out_1_2, ref8(e, int'(s)), ref2(e, int'(s12)));
            else passed++;
            exp_q  = r ? 8'h00 : ref8(e, int'(s));
            exp_q2 = r ? 2'b00 : ref2(e, int'(s12));
            tick();
            total++;
            if (out_q !== exp_q || out_1_2_q !== exp_q2 || $countones(out_q) > 1)
                $display("FAIL rand_reg n=%0d got=%b/%b exp=%b/%b", n, out_q, out_1_2_q, exp_q, exp_q2);
            else passed++;
        end
    endtask

`ifdef DECODER_ONEHOT_CHECK_EN
    task automatic test_onehot_check();
        total++;
        if (onehot_err !== 1'b0) $display("FAIL onehot_err_sweep got=%b exp=0", onehot_err);
        else passed++;
        drive(1'b1, 1'b0, 3'd0, 1'b0);
        tick();
        total++;
        if (onehot_err !== 1'b0) $display("FAIL onehot_err_rst got=%b exp=0", onehot_err);
        else passed++;
    endtask
`endif

    initial begin
        rst = 1'b1; ena = 1'b0; in = 3'd0; in_1_2 = 1'b0;
        test_reset();
        test_sweep(1'b1);
        test_sweep(1'b0);
        test_1_2();
        test_rst_mid();
        test_independence();
        test_disabled_x();
        test_random();
`ifdef DECODER_ONEHOT_CHECK_EN
        test_onehot_check();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
